data_ram_bank: RTL and testbench
================================

DATA_RAM_BANK -- requirements
Module: data_ram_bank

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 6, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter CLEAR_VAL, default 0, DATA_W-bit value written by the clear engine.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 wr  input  1  write request.
REQ-007 rd  input  1  read request.
REQ-008 addr  input  ADDR_W  word address shared by rd and wr.
REQ-009 wr_data  input  DATA_W  write data.
REQ-010 wr_be  input  DATA_W/8  byte-lane write enable; bit i gates wr_data[8i+7:8i].
REQ-011 clr_req  input  1  request a full-memory clear sweep.
REQ-012 rd_data  output  DATA_W  registered read data.
REQ-013 rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-014 busy  output  1  high while clear engine owns memory.
REQ-015 acc_err  output  1  one-cycle pulse, rd/wr request rejected.
REQ-016 acc_out  output  DATA_W  registered mirror of word DEPTH-1 (accumulator).

Function
REQ-017 FSM states SHALL be IDLE and CLEAR; busy = (state == CLEAR).
REQ-018 In CLEAR, a pointer SHALL write CLEAR_VAL to word ptr each cycle, ptr from 0 to DEPTH-1, incrementing by 1.
REQ-019 CLEAR -> IDLE on the edge that writes word DEPTH-1; busy SHALL be low the following cycle; exactly DEPTH clear writes.
REQ-020 IDLE -> CLEAR, ptr = 0, when clr_req is high in IDLE; clr_req in CLEAR SHALL be ignored (no restart).
REQ-021 In IDLE with wr high, each byte lane with wr_be set SHALL update memory[addr] on that edge; lanes with wr_be clear unchanged; wr_be = 0 is a legal no-op.
REQ-022 In IDLE with rd high, rd_data SHALL equal memory[addr] on the next cycle with rd_valid high for exactly that cycle (latency 1).
REQ-023 rd and wr in the same cycle to the same address SHALL return the pre-write contents (read-first); the write still completes.
REQ-024 rd_data SHALL hold its last value when rd_valid is low.
REQ-025 rd or wr asserted while busy, or in the same cycle clr_req is accepted, SHALL be rejected: no memory change, no rd_valid, acc_err high next cycle for one cycle.
REQ-026 acc_out SHALL update on the same edge as any write, byte-masked or clear, to word DEPTH-1, and reflect the new value the next cycle.
REQ-027 Addresses SHALL wrap naturally within ADDR_W; no out-of-range condition exists.

Reset
REQ-028 While rst is high at an edge: state = CLEAR, ptr = 0, rd_data = 0, rd_valid = 0, acc_err = 0, acc_out = 0; rd/wr/clr_req ignored.
REQ-029 After rst deasserts, the clear sweep SHALL run to completion (DEPTH cycles) before any access is accepted.
REQ-030 rst asserted mid-sweep or mid-access SHALL restart the sweep from ptr = 0; the in-flight read produces no rd_valid.

Verification (DATA_W=16, ADDR_W=6, CLEAR_VAL=16'h0000 unless stated)
REQ-031 rst for 1 cycle, then idle -> busy high for 64 cycles, low on cycle 65; rd of addr 17 -> rd_data 16'h0000, rd_valid 1 cycle later.
REQ-032 wr addr 5, 16'hBEEF, wr_be 2'b11; next cycle wr addr 5, 16'h1200, wr_be 2'b10; rd addr 5 -> 16'h12EF.
REQ-033 Same cycle wr addr 9 16'hAAAA and rd addr 9 (prior 16'h0000) -> rd_data 16'h0000; rd next -> 16'hAAAA.
REQ-034 wr addr 63 16'h0042 -> acc_out 16'h0042 next cycle; clr_req -> acc_out 16'h0000 after word 63 cleared.
REQ-035 wr during busy (addr 3, 16'h5555) -> acc_err pulse 1 cycle, later rd addr 3 -> 16'h0000; clr_req during busy -> sweep length unchanged.
REQ-036 CLEAR_VAL=16'hFFFF, rst asserted at ptr 30 -> sweep restarts at 0, 64 further cycles busy, all words read 16'hFFFF.

Source files
------------

// File: rtl/data_ram_bank.sv
// data_ram_bank: single-port word RAM with byte-lane writes, a registered read port,
// a self-timed clear engine and a registered mirror of the top word (accumulator).
//
// Ports:
//   clk_i       clock, all state on rising edge
//   rst_i       synchronous active-high reset; starts a clear sweep
//   wr_i        write request (byte-masked by wr_be_i)
//   rd_i        read request, data returned one cycle later
//   addr_i      word address shared by read and write
//   wr_data_i   write data
//   wr_be_i     byte-lane write enables
//   clr_req_i   request a full-memory clear sweep
//   rd_data_o   registered read data, holds between reads
//   rd_valid_o  one-cycle pulse qualifying rd_data_o
//   busy_o      clear engine owns the memory
//   acc_err_o   one-cycle pulse: the previous cycle's rd/wr was rejected
//   acc_out_o   registered copy of word DEPTH-1
module data_ram_bank #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 6,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [DATA_W/8-1:0]   wr_be_i,
  input  logic                  clr_req_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  rd_valid_o,
  output logic                  busy_o,
  output logic                  acc_err_o,
  output logic [DATA_W-1:0]     acc_out_o
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam int unsigned NumBytes = DATA_W / 8;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [Depth];
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                acc_err_q;
  logic [DATA_W-1:0]   acc_out_q;

  logic                acc_ok;
  logic                reject;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   merged;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Clear engine: one word per cycle; leaves CLEAR on the edge writing the last word.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    acc_ok  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_req_i) begin
          state_d = StClear;
          ptr_d   = '0;
        end else begin
          acc_ok = 1'b1;
        end
      end
      StClear: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Accesses colliding with an accepted clear or a running sweep are dropped.
  assign reject  = (rd_i | wr_i) & ~acc_ok;
  assign rd_word = mem_q[addr_i];

  always_comb begin
    merged = rd_word;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      if (wr_be_i[b]) begin
        merged[8*b +: 8] = wr_data_i[8*b +: 8];
      end
    end
  end

  // Single write port shared by the clear engine and host writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_i;
    mem_wdata = merged;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = CLEAR_VAL;
    end else if (acc_ok && wr_i) begin
      mem_we = 1'b1;
    end
    if (rst_i) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StClear;
      ptr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      acc_err_q  <= 1'b0;
      acc_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= acc_ok & rd_i;
      acc_err_q  <= reject;
      // Read-first: rd_word is sampled before this edge's write lands.
      if (acc_ok && rd_i) begin
        rd_data_q <= rd_word;
      end
      if (mem_we && (mem_waddr == '1)) begin
        acc_out_q <= mem_wdata;
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = (state_q == StClear);
  assign acc_err_o  = acc_err_q;
  assign acc_out_o  = acc_out_q;

endmodule

// File: tb/tb_data_ram_bank.sv
// Bench for data_ram_bank: two instances (clear value 0 and all-ones) share stimulus and
// are compared every cycle against a word-array model; directed scenarios add literal checks.
module tb_data_ram_bank;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst, wr, rd, clr_req;
  logic [5:0]  addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;

  logic [15:0] rd_data [2];
  logic [15:0] acc_out [2];
  logic        rd_valid [2];
  logic        busy [2];
  logic        acc_err [2];

  int checks = 0;
  int errors = 0;

  // Model state
  logic [15:0] m [2][DEPTH];
  logic [15:0] cv [2];
  logic [15:0] e_rd [2];
  logic [15:0] e_acc [2];
  logic        e_rv, e_err;
  int          clear_left;

  always #5 clk = ~clk;

  data_ram_bank #(.DATA_W(16), .ADDR_W(6), .CLEAR_VAL(16'h0000)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .rd_i(rd), .addr_i(addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .clr_req_i(clr_req), .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]),
    .busy_o(busy[0]), .acc_err_o(acc_err[0]), .acc_out_o(acc_out[0])
  );

  data_ram_bank #(.DATA_W(16), .ADDR_W(6), .CLEAR_VAL(16'hFFFF)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .rd_i(rd), .addr_i(addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .clr_req_i(clr_req), .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]),
    .busy_o(busy[1]), .acc_err_o(acc_err[1]), .acc_out_o(acc_out[1])
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Effect of the coming edge, computed from the rules on whole words.
  task automatic model_step();
    logic [15:0] w;
    int idx;
    if (rst) begin
      clear_left = DEPTH;
      e_rv = 1'b0;
      e_err = 1'b0;
      for (int k = 0; k < 2; k++) begin
        e_rd[k] = '0;
        e_acc[k] = '0;
      end
    end else if (clear_left > 0) begin
      idx = DEPTH - clear_left;
      for (int k = 0; k < 2; k++) begin
        m[k][idx] = cv[k];
        if (idx == DEPTH - 1) e_acc[k] = cv[k];
      end
      clear_left--;
      e_rv = 1'b0;
      e_err = rd | wr;
    end else if (clr_req) begin
      clear_left = DEPTH;
      e_rv = 1'b0;
      e_err = rd | wr;
    end else begin
      e_err = 1'b0;
      e_rv = rd;
      for (int k = 0; k < 2; k++) begin
        if (rd) e_rd[k] = m[k][addr];
        if (wr) begin
          w = m[k][addr];
          if (wr_be[0]) w[7:0] = wr_data[7:0];
          if (wr_be[1]) w[15:8] = wr_data[15:8];
          m[k][addr] = w;
          if (addr == 6'd63) e_acc[k] = w;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), {31'd0, busy[k]}, {31'd0, clear_left > 0});
      chk($sformatf("rd_valid%0d", k), {31'd0, rd_valid[k]}, {31'd0, e_rv});
      chk($sformatf("acc_err%0d", k), {31'd0, acc_err[k]}, {31'd0, e_err});
      chk($sformatf("rd_data%0d", k), {16'd0, rd_data[k]}, {16'd0, e_rd[k]});
      chk($sformatf("acc_out%0d", k), {16'd0, acc_out[k]}, {16'd0, e_acc[k]});
    end
  endtask

  task automatic idle_in();
    rst = 1'b0; wr = 1'b0; rd = 1'b0; clr_req = 1'b0;
    addr = '0; wr_data = '0; wr_be = '0;
  endtask

  task automatic do_wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
    idle_in();
    wr = 1'b1; addr = a; wr_data = d; wr_be = be;
    tick();
  endtask

  task automatic do_rd(input logic [5:0] a);
    idle_in();
    rd = 1'b1; addr = a;
    tick();
  endtask

  task automatic run_until_idle(output int n);
    idle_in();
    n = 0;
    while (busy[0] && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    cv[0] = 16'h0000;
    cv[1] = 16'hFFFF;
    clear_left = DEPTH;
    e_rv = 1'b0; e_err = 1'b0;
    for (int k = 0; k < 2; k++) begin
      e_rd[k] = '0; e_acc[k] = '0;
      for (int i = 0; i < DEPTH; i++) m[k][i] = '0;
    end
    idle_in();
    @(negedge clk);

    // Reset and the post-reset sweep length
    rst = 1'b1;
    tick();
    chk("busy_after_rst", {31'd0, busy[0]}, 32'd1);
    run_until_idle(n);
    chk("sweep_len", n, 64);

    do_rd(6'd17);
    chk("rd17_data", {16'd0, rd_data[0]}, 32'h0000);
    chk("rd17_valid", {31'd0, rd_valid[0]}, 32'd1);

    // Byte-lane merge
    do_wr(6'd5, 16'hBEEF, 2'b11);
    do_wr(6'd5, 16'h1200, 2'b10);
    do_rd(6'd5);
    chk("be_merge", {16'd0, rd_data[0]}, 32'h12EF);
    do_wr(6'd5, 16'h7777, 2'b00);
    do_rd(6'd5);
    chk("be_zero_noop", {16'd0, rd_data[0]}, 32'h12EF);

    // Read-first on same address
    idle_in();
    wr = 1'b1; rd = 1'b1; addr = 6'd9; wr_data = 16'hAAAA; wr_be = 2'b11;
    tick();
    chk("rdfirst_old", {16'd0, rd_data[0]}, 32'h0000);
    chk("rdfirst_old1", {16'd0, rd_data[1]}, 32'hFFFF);
    do_rd(6'd9);
    chk("rdfirst_new", {16'd0, rd_data[0]}, 32'hAAAA);
    idle_in();
    tick();
    chk("rd_valid_drop", {31'd0, rd_valid[0]}, 32'd0);
    chk("rd_data_hold", {16'd0, rd_data[0]}, 32'hAAAA);

    // Accumulator mirror, then clear with rejected accesses and an ignored clr_req
    do_wr(6'd63, 16'h0042, 2'b11);
    chk("acc_wr", {16'd0, acc_out[0]}, 32'h0042);
    idle_in();
    clr_req = 1'b1;
    tick();
    do_wr(6'd3, 16'h5555, 2'b11);
    chk("acc_err_pulse", {31'd0, acc_err[0]}, 32'd1);
    idle_in();
    clr_req = 1'b1;
    tick();
    chk("acc_err_one", {31'd0, acc_err[0]}, 32'd0);
    run_until_idle(n);
    chk("sweep_len_clr", n + 2, 64);
    chk("acc_clr0", {16'd0, acc_out[0]}, 32'h0000);
    chk("acc_clr1", {16'd0, acc_out[1]}, 32'hFFFF);
    do_rd(6'd3);
    chk("rej_wr", {16'd0, rd_data[0]}, 32'h0000);

    // Reset mid-sweep at ptr 30 restarts the sweep
    idle_in();
    rst = 1'b1;
    tick();
    idle_in();
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1;
    tick();
    run_until_idle(n);
    chk("sweep_restart", n, 64);
    n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_rd(i[5:0]);
      if (rd_data[1] === 16'hFFFF) n++;
    end
    chk("all_ffff", n, 64);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      idle_in();
      rst = ($urandom_range(0, 499) == 0);
      clr_req = ($urandom_range(0, 79) == 0);
      wr = $urandom_range(0, 1) == 1;
      rd = $urandom_range(0, 1) == 1;
      addr = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
      wr_data = 16'($urandom);
      wr_be = 2'($urandom_range(0, 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
